mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one cache port between instruction and data masters.
// Data has priority; a saturating starvation counter forces an instruction grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_rd,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_waitrequest,
  input  logic                  d_rd,
  input  logic                  d_wr,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wr_data,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  d_waitrequest,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_waitrequest
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOCK_I = 2'd1;
  localparam logic [1:0] LOCK_D = 2'd2;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] starve_cnt;
  logic [7:0] starve_nxt;
  logic       d_req;
  logic       starved;
  logic       grant_i;
  logic       grant_d;

  assign d_req   = d_rd | d_wr;
  assign starved = starve_cnt >= LIMIT;

  // Grants are held low during reset so no strobe escapes.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          grant_d = d_req & ~starved;
          grant_i = i_rd & (~d_req | starved);
        end
        LOCK_I:  grant_i = 1'b1;
        LOCK_D:  grant_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = d_addr;
    unique case (1'b1)
      grant_i: begin
        mem_rd   = i_rd;
        mem_addr = i_addr;
      end
      grant_d: begin
        mem_wr   = d_wr;
        mem_rd   = d_rd & ~d_wr;
        mem_addr = d_addr;
      end
      default: ;
    endcase
  end

  assign mem_wr_data = d_wr_data;
  assign i_data      = mem_data;
  assign d_data      = mem_data;

  assign i_waitrequest = grant_i ? mem_waitrequest : i_rd;
  assign d_waitrequest = grant_d ? mem_waitrequest : d_req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_i && mem_waitrequest)
          state_nxt = LOCK_I;
        else if (grant_d && mem_waitrequest)
          state_nxt = LOCK_D;
      end
      LOCK_I, LOCK_D: begin
        if (!mem_waitrequest)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    starve_nxt = 8'd0;
    if (i_rd && !grant_i)
      starve_nxt = starved ? LIMIT : starve_cnt + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then
// constrained-random traffic obeying the waitrequest handshake.
module tb_mem_arbiter;

  localparam int LIM = 4;

  logic        clock;
  logic        reset;
  logic        i_rd;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        i_waitrequest;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic [31:0] d_data;
  logic        d_waitrequest;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_data;
  logic        mem_waitrequest;

  mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_rd           (i_rd),
    .i_addr         (i_addr),
    .i_data         (i_data),
    .i_waitrequest  (i_waitrequest),
    .d_rd           (d_rd),
    .d_wr           (d_wr),
    .d_addr         (d_addr),
    .d_wr_data      (d_wr_data),
    .d_data         (d_data),
    .d_waitrequest  (d_waitrequest),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wr_data    (mem_wr_data),
    .mem_data       (mem_data),
    .mem_waitrequest(mem_waitrequest)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic        act;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] idat;
    logic [31:0] ddat;
    logic        iw;
    logic        dw;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t obs;
  exp_t last;

  int checks   = 0;
  int failures = 0;
  int m_state  = 0;
  int m_cnt    = 0;
  logic m_gi;
  logic m_gd;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic ir,
                     input logic [31:0] ia, input logic dr,
                     input logic dwr, input logic [31:0] da,
                     input logic [31:0] wd, input logic mw,
                     input logic [31:0] md);
    exp_t e;
    exp_t x;
    logic dq;
    reset = rst; i_rd = ir; i_addr = ia;
    d_rd = dr; d_wr = dwr; d_addr = da; d_wr_data = wd;
    mem_waitrequest = mw; mem_data = md;
    dq = dr | dwr;
    m_gi = 1'b0;
    m_gd = 1'b0;
    if (!rst) begin
      case (m_state)
        0: begin
          m_gd = dq && (m_cnt < LIM);
          m_gi = ir && (!dq || m_cnt == LIM);
        end
        1: m_gi = 1'b1;
        default: m_gd = 1'b1;
      endcase
    end
    e.rd   = m_gi ? ir : (m_gd ? (dr & ~dwr) : 1'b0);
    e.wr   = m_gd & dwr;
    e.act  = m_gi | m_gd;
    e.addr = m_gi ? ia : da;
    e.wd   = wd;
    e.idat = md;
    e.ddat = md;
    e.iw   = m_gi ? mw : ir;
    e.dw   = m_gd ? mw : dq;
    e.cnt  = 8'(m_cnt);
    sbq.push_back(e);
    @(negedge clock);
    x.rd = mem_rd; x.wr = mem_wr; x.act = mem_rd | mem_wr;
    x.addr = mem_addr; x.wd = mem_wr_data;
    x.idat = i_data; x.ddat = d_data;
    x.iw = i_waitrequest; x.dw = d_waitrequest;
    x.cnt = dut.starve_cnt;
    obs = x;
    e = sbq.pop_front();
    last = e;
    chk("mem_rd", 64'(x.rd), 64'(e.rd));
    chk("mem_wr", 64'(x.wr), 64'(e.wr));
    if (e.act) chk("mem_addr", 64'(x.addr), 64'(e.addr));
    chk("mem_wr_data", 64'(x.wd), 64'(e.wd));
    chk("i_data", 64'(x.idat), 64'(e.idat));
    chk("d_data", 64'(x.ddat), 64'(e.ddat));
    chk("i_wait", 64'(x.iw), 64'(e.iw));
    chk("d_wait", 64'(x.dw), 64'(e.dw));
    chk("starve_cnt", 64'(x.cnt), 64'(e.cnt));
    @(posedge clock);
    if (rst) begin
      m_state = 0;
      m_cnt   = 0;
    end else begin
      if (ir && !m_gi) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
      else m_cnt = 0;
      case (m_state)
        0: begin
          if (m_gi && mw) m_state = 1;
          else if (m_gd && mw) m_state = 2;
        end
        default: if (!mw) m_state = 0;
      endcase
    end
    #1;
  endtask

  initial begin
    logic ip, dp, prd, pwr;
    logic [31:0] pia, pda, pwd;
    logic rs, mw;
    reset = 1'b1; i_rd = 0; i_addr = 0; d_rd = 0; d_wr = 0;
    d_addr = 0; d_wr_data = 0; mem_data = 0; mem_waitrequest = 0;
    repeat (2) @(posedge clock);
    #1;

    // reset with both ports requesting
    cyc(1, 1, 32'h8, 1, 0, 32'h9, 32'h0, 0, 32'h0);
    chk("rst_mem_rd", 64'(obs.rd), 64'(1'b0));
    chk("rst_i_wait", 64'(obs.iw), 64'(1'b1));
    chk("rst_d_wait", 64'(obs.dw), 64'(1'b1));

    // idle, nothing pending
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("idle_rd", 64'(obs.rd | obs.wr), 64'(1'b0));
    chk("idle_wait", 64'({obs.iw, obs.dw}), 64'(2'b00));

    // single instruction read
    cyc(0, 1, 32'h10, 0, 0, 32'h0, 32'h0, 0, 32'h1234);
    chk("i_only_rd", 64'(obs.rd), 64'(1'b1));
    chk("i_only_addr", 64'(obs.addr), 64'(32'h10));
    chk("i_only_wait", 64'(obs.iw), 64'(1'b0));
    chk("i_only_data", 64'(obs.idat), 64'(32'h1234));
    chk("i_only_state", 64'(dut.state), 64'(0));

    // data write beats pending instruction
    cyc(0, 1, 32'h44, 0, 1, 32'h20, 32'hDEADBEEF, 0, 32'h0);
    chk("dw_wr", 64'(obs.wr), 64'(1'b1));
    chk("dw_addr", 64'(obs.addr), 64'(32'h20));
    chk("dw_wdata", 64'(obs.wd), 64'(32'hDEADBEEF));
    chk("dw_i_wait", 64'(obs.iw), 64'(1'b1));
    chk("dw_d_wait", 64'(obs.dw), 64'(1'b0));

    // read and write together: write wins
    cyc(0, 0, 32'h0, 1, 1, 32'h24, 32'h55, 0, 32'h0);
    chk("rw_both", 64'({obs.wr, obs.rd}), 64'(2'b10));

    // locked data read, instruction arrives mid-lock
    cyc(0, 0, 32'h0, 1, 0, 32'h30, 32'h0, 1, 32'h0);
    chk("lockd_c1_wait", 64'(obs.dw), 64'(1'b1));
    chk("lockd_c1_state", 64'(dut.state), 64'(2));
    for (int k = 2; k <= 3; k++) begin
      cyc(0, 1, 32'h40, 1, 0, 32'h30, 32'h0, 1, 32'h0);
      chk("lockd_addr", 64'(obs.addr), 64'(32'h30));
      chk("lockd_i_wait", 64'(obs.iw), 64'(1'b1));
    end
    cyc(0, 1, 32'h40, 1, 0, 32'h30, 32'h0, 0, 32'hCAFE);
    chk("lockd_c4_dwait", 64'(obs.dw), 64'(1'b0));
    chk("lockd_c4_iwait", 64'(obs.iw), 64'(1'b1));
    chk("lockd_c4_data", 64'(obs.ddat), 64'(32'hCAFE));
    chk("lockd_c4_state", 64'(dut.state), 64'(0));
    cyc(0, 1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0);
    chk("lockd_c5_addr", 64'(obs.addr), 64'(32'h40));
    chk("lockd_c5_iwait", 64'(obs.iw), 64'(1'b0));

    // starvation: data wins 4 cycles, instruction the 5th
    for (int k = 1; k <= 6; k++) begin
      cyc(0, 1, 32'h100, 1, 0, 32'h200, 32'h0, 0, 32'h0);
      if (k == 5) begin
        chk("starve_i_grant", 64'({obs.iw, obs.dw}), 64'(2'b01));
        chk("starve_i_addr", 64'(obs.addr), 64'(32'h100));
      end else begin
        chk("starve_d_grant", 64'({obs.iw, obs.dw}), 64'(2'b10));
        chk("starve_d_addr", 64'(obs.addr), 64'(32'h200));
      end
      if (k == 6) chk("starve_c6_cnt", 64'(obs.cnt), 64'(0));
    end
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    // reset abandons a locked instruction fetch
    cyc(0, 1, 32'h50, 0, 0, 32'h0, 32'h0, 1, 32'h0);
    chk("locki_state", 64'(dut.state), 64'(1));
    cyc(1, 1, 32'h50, 0, 0, 32'h0, 32'h0, 1, 32'h0);
    chk("locki_rst_rd", 64'(obs.rd), 64'(1'b0));
    chk("locki_rst_iwait", 64'(obs.iw), 64'(1'b1));
    chk("locki_post_state", 64'(dut.state), 64'(0));
    chk("locki_post_cnt", 64'(dut.starve_cnt), 64'(0));
    cyc(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0);

    // random traffic, requests held until completion
    ip = 0; dp = 0; prd = 0; pwr = 0;
    pia = 0; pda = 0; pwd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!ip && $urandom_range(1, 0) == 1) begin
        ip = 1; pia = $urandom;
      end
      if (!dp && $urandom_range(2, 0) != 0) begin
        dp = 1; pda = $urandom; pwd = $urandom;
        case ($urandom_range(2, 0))
          0: begin prd = 1; pwr = 0; end
          1: begin prd = 0; pwr = 1; end
          default: begin prd = 1; pwr = 1; end
        endcase
      end
      rs = ($urandom_range(39, 0) == 0);
      mw = ($urandom_range(2, 0) == 0);
      cyc(rs, ip, pia, dp & prd, dp & pwr, pda, pwd, mw, $urandom);
      if (rs) begin
        ip = 0; dp = 0;
      end else begin
        if (ip && !last.iw) ip = 0;
        if (dp && !last.dw) dp = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
